// File: rtl/sprinkler_pkg.sv
// Shared irrigation definitions: valve FSM state encoding and default timing constants.
package sprinkler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPENING = 2'd1,
    ST_ON      = 2'd2,
    ST_LOCKOUT = 2'd3
  } sprinkler_state_e;

  localparam int unsigned SPRK_OPEN_CYCLES    = 4;
  localparam int unsigned SPRK_MIN_ON_CYCLES  = 16;
  localparam int unsigned SPRK_MAX_ON_CYCLES  = 64;
  localparam int unsigned SPRK_MIN_OFF_CYCLES = 8;
  localparam int unsigned SPRK_CNT_W          = 8;

endpackage

// File: rtl/sprinkler_cycle_timer.sv
// Clearable saturating up-counter with a compare-to-limit flag (count >= limit).
module sprinkler_cycle_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // next count: clear has priority, otherwise count up and hold at all-ones
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {CNT_W{1'b0}};
    end else if (count_q != CNT_MAX) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = (count_q >= limit_i);

endmodule

// File: rtl/sprinkler_valve_driver.sv
// Timed, interlocked valve command from the sprinkler request line.
// Optional watchdog (max on-time, sticky fault) enabled by SPRINKLER_VALVE_WATCHDOG_EN.
module sprinkler_valve_driver
  import sprinkler_pkg::*;
#(
  parameter int unsigned OPEN_CYCLES    = SPRK_OPEN_CYCLES,
  parameter int unsigned MIN_ON_CYCLES  = SPRK_MIN_ON_CYCLES,
  parameter int unsigned MAX_ON_CYCLES  = SPRK_MAX_ON_CYCLES,
  parameter int unsigned MIN_OFF_CYCLES = SPRK_MIN_OFF_CYCLES,
  parameter int unsigned CNT_W          = SPRK_CNT_W
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sprinkler_request_i,
  input  logic       fault_clear_i,
  output logic       valve_open_o,
  output logic       valve_ack_o,
  output logic       valve_busy_o,
  output logic       fault_o,
  output logic [7:0] cycle_count_o
);

  // The timer restarts in ON, so on-time limits are offset by the OPENING cycles already spent.
  localparam logic [CNT_W-1:0] OPEN_LIM    = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_ON_LIM  = CNT_W'(MIN_ON_CYCLES - OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_OFF_LIM = CNT_W'(MIN_OFF_CYCLES - 1);

  sprinkler_state_e state_q, state_d;
  logic             valve_open_q, valve_open_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             tmr_clear_s;
  logic [CNT_W-1:0] tmr_limit_s;
  logic [CNT_W-1:0] tmr_count_s;
  logic             tmr_done_s;
  logic             wd_trip_s;

  sprinkler_cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (tmr_clear_s),
    .limit_i (tmr_limit_s),
    .count_o (tmr_count_s),
    .done_o  (tmr_done_s)
  );

`ifdef SPRINKLER_VALVE_WATCHDOG_EN
  localparam logic [CNT_W-1:0] MAX_ON_LIM = CNT_W'(MAX_ON_CYCLES - OPEN_CYCLES - 1);

  assign wd_trip_s = (state_q == ST_ON) && (tmr_count_s >= MAX_ON_LIM);

  // sticky fault: a watchdog trip outranks a simultaneous clear
  always_comb begin
    fault_d = fault_q;
    if (wd_trip_s) begin
      fault_d = 1'b1;
    end else if (fault_clear_i) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end
  end
`else
  logic unused_wd_s;

  assign wd_trip_s   = 1'b0;
  assign unused_wd_s = fault_clear_i ^ (^tmr_count_s) ^ (MAX_ON_CYCLES == 32'd0);

  // no watchdog: fault is held low
  always_comb begin
    fault_d = 1'b0;
  end
`endif

  // next-state logic and timer limit selection
  always_comb begin
    state_d     = state_q;
    tmr_limit_s = OPEN_LIM;
    case (state_q)
      ST_IDLE: begin
        if (sprinkler_request_i && !fault_q) begin
          state_d = ST_OPENING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OPENING: begin
        tmr_limit_s = OPEN_LIM;
        if (tmr_done_s) begin
          state_d = ST_ON;
        end else begin
          state_d = ST_OPENING;
        end
      end
      ST_ON: begin
        tmr_limit_s = MIN_ON_LIM;
        if (wd_trip_s) begin
          state_d = ST_LOCKOUT;
        end else if (!sprinkler_request_i && tmr_done_s) begin
          state_d = ST_LOCKOUT;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_LOCKOUT: begin
        tmr_limit_s = MIN_OFF_LIM;
        if (tmr_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCKOUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tmr_clear_s = (state_d != state_q);

  // output next values derived from the upcoming state so every output is a flop
  always_comb begin
    valve_open_d = (state_d == ST_OPENING) || (state_d == ST_ON);
    ack_d        = (state_q == ST_OPENING) && (state_d == ST_ON);
    busy_d       = (state_d != ST_IDLE);
    if ((state_d == ST_LOCKOUT) && (state_q != ST_LOCKOUT)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // state and output registers; reset closes the valve immediately
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      valve_open_q <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      valve_open_q <= valve_open_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      cnt_q        <= cnt_d;
    end
  end

  assign valve_open_o  = valve_open_q;
  assign valve_ack_o   = ack_q;
  assign valve_busy_o  = busy_q;
  assign fault_o       = fault_q;
  assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_sprinkler_valve_driver.sv
// Table-driven directed bench for sprinkler_valve_driver; follows SPRINKLER_VALVE_WATCHDOG_EN.
module tb_sprinkler_valve_driver;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       req;
  logic       clr;
  logic       valve_open;
  logic       valve_ack;
  logic       valve_busy;
  logic       fault;
  logic [7:0] cycle_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       req;
    logic       clr;
    int         n;
    logic       open;
    logic       ack;
    logic       busy;
    logic       fault;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  always #5 clk_i = ~clk_i;

  sprinkler_valve_driver dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .sprinkler_request_i (req),
    .fault_clear_i       (clr),
    .valve_open_o        (valve_open),
    .valve_ack_o         (valve_ack),
    .valve_busy_o        (valve_busy),
    .fault_o             (fault),
    .cycle_count_o       (cycle_count)
  );

  task automatic add(input logic r, input logic c, input int n, input logic o,
                     input logic a, input logic b, input logic f, input logic [7:0] cnt);
    vec_t v;
    v.req = r; v.clr = c; v.n = n;
    v.open = o; v.ack = a; v.busy = b; v.fault = f; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic c);
    req = r;
    clr = c;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic o, input logic a, input logic b,
                       input logic f, input logic [7:0] cnt);
    checks++;
    if ({valve_open, valve_ack, valve_busy, fault, cycle_count} !== {o, a, b, f, cnt}) begin
      errors++;
      $display("FAIL %s: open/ack/busy/fault/cnt got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
               name, valve_open, valve_ack, valve_busy, fault, cycle_count, o, a, b, f, cnt);
    end
  endtask

  initial begin
    // idle after reset
    add(1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    // single-cycle request: open 16 cycles, ack at 5th open cycle, lockout 8
    add(1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b0, 11, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b0, 8,  1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    add(1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    // request held 40 cycles: open exactly 40
    add(1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    add(1'b1, 1'b0, 3,  1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
    add(1'b1, 1'b0, 35, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    add(1'b0, 1'b0, 8,  1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    // request re-asserted in lockout: 9 closed cycles before reopening
    add(1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b0, 11, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
    add(1'b1, 1'b0, 7,  1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
    add(1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    add(1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
    add(1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
    add(1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b1, 1'b0, 8'd3);
    add(1'b0, 1'b0, 11, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
    add(1'b0, 1'b0, 8,  1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
    add(1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
`ifdef SPRINKLER_VALVE_WATCHDOG_EN
    // held request: open exactly 64, fault set on the closing edge even with clear asserted
    add(1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b1, 1'b0, 8'd4);
    add(1'b1, 1'b0, 3,  1'b1, 1'b0, 1'b1, 1'b0, 8'd4);
    add(1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b1, 1'b0, 8'd4);
    add(1'b1, 1'b0, 58, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4);
    add(1'b1, 1'b1, 1,  1'b1, 1'b0, 1'b1, 1'b0, 8'd4);
    add(1'b1, 1'b1, 1,  1'b0, 1'b0, 1'b1, 1'b1, 8'd5);
    add(1'b1, 1'b0, 7,  1'b0, 1'b0, 1'b1, 1'b1, 8'd5);
    add(1'b1, 1'b0, 3,  1'b0, 1'b0, 1'b0, 1'b1, 8'd5);
    add(1'b1, 1'b1, 1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
    add(1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b1, 1'b0, 8'd5);
    add(1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b1, 1'b0, 8'd5);
    add(1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b1, 1'b0, 8'd5);
    add(1'b0, 1'b0, 11, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5);
    add(1'b0, 1'b0, 8,  1'b0, 1'b0, 1'b1, 1'b0, 8'd6);
    add(1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd6);
`else
    // no watchdog: held 200 cycles stays open 200, clear ignored, no fault
    add(1'b1, 1'b0, 1,   1'b1, 1'b0, 1'b1, 1'b0, 8'd4);
    add(1'b1, 1'b1, 3,   1'b1, 1'b0, 1'b1, 1'b0, 8'd4);
    add(1'b1, 1'b0, 1,   1'b1, 1'b1, 1'b1, 1'b0, 8'd4);
    add(1'b1, 1'b0, 195, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4);
    add(1'b0, 1'b0, 8,   1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
    add(1'b0, 1'b0, 1,   1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
`endif

    rst_n_i = 1'b0;
    req     = 1'b0;
    clr     = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        step(vecs[i].req, vecs[i].clr);
        check($sformatf("vec%0d.%0d", i, k), vecs[i].open, vecs[i].ack, vecs[i].busy,
              vecs[i].fault, vecs[i].cnt);
      end
    end

    // asynchronous reset while ON: everything drops without a clock edge
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    check("pre_reset_on", 1'b1, 1'b0, 1'b1, 1'b0, cycle_count);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0);
    check("held_in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step(1'b1, 1'b0);
    check("no_lockout_after_reset", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    repeat (24) step(1'b0, 1'b0);
    check("post_reset_cycle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    // cycle counter wraps 255 -> 0
    for (int i = 2; i <= 256; i++) begin
      step(1'b1, 1'b0);
      repeat (24) step(1'b0, 1'b0);
      if (i >= 254) begin
        check($sformatf("wrap_%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 8'(i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
